// File: rtl/if_prefetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : if_prefetch_queue
// Purpose  : PC, loadable instruction memory and a credit-limited prefetch FIFO
//            feeding decode over valid/ready; redirect/pc_reset flush the queue.
// Revision : 1.0
// ============================================================================
module if_prefetch_queue #(
  parameter int ADDR_W   = 9,
  parameter int INST_W   = 16,
  parameter int DEPTH    = 4,
  parameter int RESET_PC = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pc_reset,
  input  logic              pc_src,
  input  logic [ADDR_W-1:0] branch_address,
  input  logic              fetch_en,
  input  logic              wen,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [INST_W-1:0] din,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [INST_W-1:0] out_inst,
  output logic [ADDR_W-1:0] out_pc,
  output logic [ADDR_W-1:0] next_address
);

  localparam int                c_PTR_W    = $clog2(DEPTH);
  localparam int                c_CNT_W    = c_PTR_W + 1;
  localparam logic [c_CNT_W:0]  c_DEPTH    = (c_CNT_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] c_RESET_PC = ADDR_W'(RESET_PC);

  logic [INST_W-1:0]  r_mem       [2**ADDR_W];
  logic [INST_W-1:0]  r_fifo_inst [DEPTH];
  logic [ADDR_W-1:0]  r_fifo_pc   [DEPTH];

  logic [ADDR_W-1:0]  r_pc;
  logic [ADDR_W-1:0]  r_rd_pc;
  logic [INST_W-1:0]  r_rd_inst;
  logic               r_inflight;
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_CNT_W-1:0] r_count;

  logic               w_flush;
  logic [c_CNT_W:0]   w_occupancy;
  logic               w_issue;
  logic               w_push;
  logic               w_pop;
  logic               w_valid;

  // Queued plus in-flight words are counted so a returning read always has a slot.
  assign w_flush     = pc_reset | pc_src;
  assign w_occupancy = {1'b0, r_count} + (c_CNT_W + 1)'(r_inflight);
  assign w_issue     = fetch_en & ~w_flush & (w_occupancy < c_DEPTH);
  assign w_push      = r_inflight & ~w_flush;
  assign w_valid     = (r_count != '0);
  assign w_pop       = w_valid & out_ready & ~w_flush;

  // Memory array is never reset; same-edge read of a written address sees old data.
  always_ff @(posedge clk) begin
    if (wen) begin
      r_mem[waddr] <= din;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc       <= c_RESET_PC;
      r_rd_pc    <= '0;
      r_rd_inst  <= '0;
      r_inflight <= 1'b0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_rd_inst <= r_mem[r_pc];
        r_rd_pc   <= r_pc;
      end

      if (pc_reset) begin
        r_pc <= c_RESET_PC;
      end else if (pc_src) begin
        r_pc <= branch_address;
      end else if (w_issue) begin
        r_pc <= r_pc + ADDR_W'(1);
      end

      if (w_flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push) begin
          r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
        end
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + c_CNT_W'(1);
          2'b01:   r_count <= r_count - c_CNT_W'(1);
          default: r_count <= r_count;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_fifo_inst[i] <= '0;
        r_fifo_pc[i]   <= '0;
      end
    end else if (w_push) begin
      r_fifo_inst[r_wr_ptr] <= r_rd_inst;
      r_fifo_pc[r_wr_ptr]   <= r_rd_pc;
    end
  end

  assign out_valid    = w_valid;
  assign out_inst     = w_valid ? r_fifo_inst[r_rd_ptr] : '0;
  assign out_pc       = w_valid ? r_fifo_pc[r_rd_ptr] : '0;
  assign next_address = w_valid ? (r_fifo_pc[r_rd_ptr] + ADDR_W'(1)) : '0;

endmodule
`default_nettype wire

// File: tb/tb_if_prefetch_queue.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_if_prefetch_queue
// Purpose  : Scoreboard bench for if_prefetch_queue streaming, stall, flush and reset.
// Revision : 1.0
// ============================================================================
module tb_if_prefetch_queue;

  localparam int ADDR_W = 9;
  localparam int INST_W = 16;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              pc_reset = 1'b0;
  logic              pc_src = 1'b0;
  logic [ADDR_W-1:0] branch_address = '0;
  logic              fetch_en = 1'b0;
  logic              wen = 1'b0;
  logic [ADDR_W-1:0] waddr = '0;
  logic [INST_W-1:0] din = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [INST_W-1:0] out_inst;
  logic [ADDR_W-1:0] out_pc;
  logic [ADDR_W-1:0] next_address;

  always #5 clk = ~clk;

  if_prefetch_queue #(
    .ADDR_W  (ADDR_W),
    .INST_W  (INST_W),
    .DEPTH   (DEPTH),
    .RESET_PC(0)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .pc_reset      (pc_reset),
    .pc_src        (pc_src),
    .branch_address(branch_address),
    .fetch_en      (fetch_en),
    .wen           (wen),
    .waddr         (waddr),
    .din           (din),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_inst      (out_inst),
    .out_pc        (out_pc),
    .next_address  (next_address)
  );

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } exp_t;

  exp_t              sb[$];
  logic [INST_W-1:0] model_mem [2**ADDR_W];
  int                checks   = 0;
  int                failures = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_range(input logic [ADDR_W-1:0] start, input int n);
    exp_t              e;
    logic [ADDR_W-1:0] p;
    p = start;
    for (int i = 0; i < n; i++) begin
      e.pc   = p;
      e.inst = model_mem[p];
      sb.push_back(e);
      p = p + ADDR_W'(1);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1 reset = 1'b0;
    for (int i = 0; i < 2**ADDR_W; i++) begin
      model_mem[i] = 16'h1000 + INST_W'(i);
      wen   = 1'b1;
      waddr = ADDR_W'(i);
      din   = model_mem[i];
      tick();
    end
    wen = 1'b0;
    checks++;
    if ({out_valid, out_inst, out_pc, next_address} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: valid=%b inst=%h pc=%h next=%h expected all 0",
               out_valid, out_inst, out_pc, next_address);
    end
  endtask

  task automatic test_stream();
    exp_t              e;
    logic [ADDR_W-1:0] nxt;
    reset = 1'b1; out_ready = 1'b1; fetch_en = 1'b1;
    sb.delete();
    push_range(9'd0, 8);
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++; $display("FAIL stream_latency1: out_valid=%b expected 0", out_valid);
    end
    tick();
    for (int i = 0; i < 8; i++) begin
      e = sb.pop_front();
      nxt = e.pc + ADDR_W'(1);
      checks++;
      if (out_valid !== 1'b1 || out_pc !== e.pc || out_inst !== e.inst || next_address !== nxt) begin
        failures++;
        $display("FAIL stream_word%0d: valid=%b pc=%h inst=%h next=%h expected 1 %h %h %h",
                 i, out_valid, out_pc, out_inst, next_address, e.pc, e.inst, nxt);
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    exp_t              e;
    logic [ADDR_W-1:0] nxt;
    out_ready = 1'b1;
    pc_reset = 1'b1; tick(); pc_reset = 1'b0;
    sb.delete();
    push_range(9'd0, 8);
    for (int b = 0; b < 8 && !out_valid; b++) tick();
    e = sb.pop_front();
    checks++;
    if (out_valid !== 1'b1 || out_pc !== e.pc || out_inst !== e.inst) begin
      failures++;
      $display("FAIL bp_first: valid=%b pc=%h inst=%h expected 1 %h %h", out_valid, out_pc, out_inst, e.pc, e.inst);
    end
    tick();
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 9'd1) begin
        failures++;
        $display("FAIL bp_hold%0d: valid=%b pc=%h expected 1 001", i, out_valid, out_pc);
      end
    end
    checks++;
    if (dut.r_count !== 3'd4 || dut.r_pc !== 9'd5) begin
      failures++;
      $display("FAIL bp_saturate: count=%0d pc=%h expected 4 005", dut.r_count, dut.r_pc);
    end
    out_ready = 1'b1;
    for (int b = 0; b < 40 && sb.size() > 0; b++) begin
      if (out_valid) begin
        e = sb.pop_front();
        nxt = e.pc + ADDR_W'(1);
        checks++;
        if (out_pc !== e.pc || out_inst !== e.inst || next_address !== nxt) begin
          failures++;
          $display("FAIL bp_drain: pc=%h inst=%h next=%h expected %h %h %h", out_pc, out_inst, next_address, e.pc, e.inst, nxt);
        end
      end
      tick();
    end
    checks++;
    if (sb.size() != 0) begin
      failures++; $display("FAIL bp_timeout: %0d words outstanding expected 0", sb.size()); sb.delete();
    end
  endtask

  task automatic test_redirect();
    exp_t              e;
    logic [ADDR_W-1:0] nxt;
    out_ready = 1'b1;
    pc_reset = 1'b1; tick(); pc_reset = 1'b0;
    sb.delete();
    push_range(9'd0, 3);
    for (int b = 0; b < 20; b++) begin
      if (out_valid && out_pc == 9'd3) break;
      if (out_valid) begin
        e = sb.pop_front();
        checks++;
        if (out_pc !== e.pc || out_inst !== e.inst) begin
          failures++;
          $display("FAIL redir_pre: pc=%h inst=%h expected %h %h", out_pc, out_inst, e.pc, e.inst);
        end
      end
      tick();
    end
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 9'd3 || sb.size() != 0) begin
      failures++;
      $display("FAIL redir_head3: valid=%b pc=%h left=%0d expected 1 003 0", out_valid, out_pc, sb.size());
    end
    sb.delete();
    pc_src = 1'b1; branch_address = 9'h100;
    tick();
    pc_src = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || out_inst !== '0) begin
      failures++; $display("FAIL redir_kill1: valid=%b inst=%h expected 0 0000", out_valid, out_inst);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++; $display("FAIL redir_kill2: valid=%b expected 0", out_valid);
    end
    tick();
    push_range(9'h100, 2);
    for (int i = 0; i < 2; i++) begin
      e = sb.pop_front();
      nxt = e.pc + ADDR_W'(1);
      checks++;
      if (out_valid !== 1'b1 || out_pc !== e.pc || out_inst !== e.inst || next_address !== nxt) begin
        failures++;
        $display("FAIL redir_target%0d: valid=%b pc=%h inst=%h next=%h expected 1 %h %h %h",
                 i, out_valid, out_pc, out_inst, next_address, e.pc, e.inst, nxt);
      end
      tick();
    end
  endtask

  task automatic test_flush_priority();
    exp_t              e;
    logic [ADDR_W-1:0] nxt;
    out_ready = 1'b1;
    pc_reset = 1'b1; pc_src = 1'b1; branch_address = 9'h050;
    tick();
    pc_reset = 1'b0; pc_src = 1'b0;
    sb.delete();
    push_range(9'd0, 3);
    for (int b = 0; b < 20 && sb.size() > 0; b++) begin
      if (out_valid) begin
        e = sb.pop_front();
        nxt = e.pc + ADDR_W'(1);
        checks++;
        if (out_pc !== e.pc || out_inst !== e.inst || next_address !== nxt) begin
          failures++;
          $display("FAIL prio_stream: pc=%h inst=%h next=%h expected %h %h %h", out_pc, out_inst, next_address, e.pc, e.inst, nxt);
        end
      end
      tick();
    end
    checks++;
    if (sb.size() != 0) begin
      failures++; $display("FAIL prio_timeout: %0d words outstanding expected 0", sb.size()); sb.delete();
    end
  endtask

  task automatic test_wrap();
    exp_t              e;
    logic [ADDR_W-1:0] nxt;
    out_ready = 1'b1;
    pc_src = 1'b1; branch_address = 9'h1FF;
    tick();
    pc_src = 1'b0;
    sb.delete();
    push_range(9'h1FF, 3);
    for (int b = 0; b < 20 && sb.size() > 0; b++) begin
      if (out_valid) begin
        e = sb.pop_front();
        nxt = e.pc + ADDR_W'(1);
        checks++;
        if (out_pc !== e.pc || out_inst !== e.inst || next_address !== nxt) begin
          failures++;
          $display("FAIL wrap_stream: pc=%h inst=%h next=%h expected %h %h %h", out_pc, out_inst, next_address, e.pc, e.inst, nxt);
        end
      end
      tick();
    end
    checks++;
    if (sb.size() != 0) begin
      failures++; $display("FAIL wrap_timeout: %0d words outstanding expected 0", sb.size()); sb.delete();
    end
  endtask

  task automatic test_async_reset_and_write();
    exp_t              e;
    logic [ADDR_W-1:0] nxt;
    out_ready = 1'b1;
    pc_reset = 1'b1; tick(); pc_reset = 1'b0;
    for (int b = 0; b < 8 && !out_valid; b++) tick();
    out_ready = 1'b0;
    tick(); tick();
    checks++;
    if (out_valid !== 1'b1 || dut.r_count !== 3'd3) begin
      failures++; $display("FAIL ar_fill: valid=%b count=%0d expected 1 3", out_valid, dut.r_count);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({out_valid, out_inst, out_pc, next_address} !== '0) begin
      failures++;
      $display("FAIL ar_immediate: valid=%b inst=%h pc=%h next=%h expected all 0", out_valid, out_inst, out_pc, next_address);
    end
    tick();
    reset = 1'b1; out_ready = 1'b1;
    waddr = 9'd5; din = 16'hBEEF;
    sb.delete();
    push_range(9'd0, 8);
    for (int c = 0; c < 40 && sb.size() > 0; c++) begin
      if (out_valid) begin
        e = sb.pop_front();
        nxt = e.pc + ADDR_W'(1);
        checks++;
        if (out_pc !== e.pc || out_inst !== e.inst || next_address !== nxt) begin
          failures++;
          $display("FAIL ar_restart: pc=%h inst=%h next=%h expected %h %h %h", out_pc, out_inst, next_address, e.pc, e.inst, nxt);
        end
      end
      wen = (c == 5);
      tick();
    end
    wen = 1'b0;
    model_mem[5] = 16'hBEEF;
    checks++;
    if (sb.size() != 0) begin
      failures++; $display("FAIL ar_timeout: %0d words outstanding expected 0", sb.size()); sb.delete();
    end
    pc_src = 1'b1; branch_address = 9'd5;
    tick();
    pc_src = 1'b0;
    push_range(9'd5, 2);
    for (int b = 0; b < 20 && sb.size() > 0; b++) begin
      if (out_valid) begin
        e = sb.pop_front();
        checks++;
        if (out_pc !== e.pc || out_inst !== e.inst) begin
          failures++;
          $display("FAIL wr_newdata: pc=%h inst=%h expected %h %h", out_pc, out_inst, e.pc, e.inst);
        end
      end
      tick();
    end
    checks++;
    if (sb.size() != 0) begin
      failures++; $display("FAIL wr_timeout: %0d words outstanding expected 0", sb.size()); sb.delete();
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_flush_priority();
    test_wrap();
    test_async_reset_and_write();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
